// File: rtl/irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// irq_sequencer_if
// Bundles the signals between the interrupt sequencer, the peripherals and
// the core control FSM.
//   master : the core/peripheral side (drives requests, boundary, config)
//   slave  : the sequencer itself
// Signals:
//   irq_in      raw request lines, synchronous to clk, rising edge requests
//   boundary    an instruction is completing this cycle
//   pc_next     PC the core would load at this boundary without interrupt
//   mret        completing instruction is MRET (qualified by boundary)
//   cfg_we      write mask / global enable
//   cfg_mask    new mask (1 = enabled)
//   cfg_gie     new global interrupt enable
//   clr_we      clear pending bits
//   clr_bits    bits to clear
//   interrupt   take ISR this cycle (combinational)
//   isr_target  vector of the selected IRQ (combinational)
//   isr_return  saved return PC (registered)
//   in_isr      ISR active
//   active_id   ID of the IRQ being serviced
//   pending     pending register
// ---------------------------------------------------------------------------
interface irq_sequencer_if #(
  parameter int NUM_IRQ = 4
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irq_in;
  logic               boundary;
  logic [15:0]        pc_next;
  logic               mret;
  logic               cfg_we;
  logic [NUM_IRQ-1:0] cfg_mask;
  logic               cfg_gie;
  logic               clr_we;
  logic [NUM_IRQ-1:0] clr_bits;
  logic               interrupt;
  logic [15:0]        isr_target;
  logic [15:0]        isr_return;
  logic               in_isr;
  logic [ID_W-1:0]    active_id;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq_in, boundary, pc_next, mret, cfg_we, cfg_mask, cfg_gie,
           clr_we, clr_bits,
    input  interrupt, isr_target, isr_return, in_isr, active_id, pending
  );

  modport slave (
    input  irq_in, boundary, pc_next, mret, cfg_we, cfg_mask, cfg_gie,
           clr_we, clr_bits,
    output interrupt, isr_target, isr_return, in_isr, active_id, pending
  );
endinterface

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
// Single-level interrupt controller. Latches rising edges of the request
// lines into a pending register, masks them, and at an instruction boundary
// redirects the PC to the vector of the lowest-numbered eligible request.
// MRET at a boundary while servicing returns to normal flow.
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    irq_sequencer_if.slave (requests, core handshake, config, status)
// ---------------------------------------------------------------------------
module irq_sequencer #(
  parameter int          NUM_IRQ       = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic           clk,
  input  logic           reset,
  irq_sequencer_if.slave bus
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_ISR = 1'b1
  } state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic               gie_q;
  logic [15:0]        isr_return_q;
  logic [ID_W-1:0]    active_id_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel_id;
  logic               take;

  assign rise     = bus.irq_in & ~irq_prev_q;
  assign eligible = gie_q ? (pending_q & mask_q) : '0;

  // Fixed priority: scanning downward leaves the lowest set index in sel_id.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  // MRET suppresses entry so at least one instruction runs at the return PC.
  assign take = (state_q == IDLE) && bus.boundary && !bus.mret && (eligible != '0);

  // A new edge beats both the service clear and the software clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (rise[i])                             pending_d[i] = 1'b1;
      else if (take && (sel_id == ID_W'(i)))   pending_d[i] = 1'b0;
      else if (bus.clr_we && bus.clr_bits[i])  pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      isr_return_q <= '0;
      active_id_q  <= '0;
    end else begin
      irq_prev_q <= bus.irq_in;
      pending_q  <= pending_d;
      if (bus.cfg_we) begin
        mask_q <= bus.cfg_mask;
        gie_q  <= bus.cfg_gie;
      end
      case (state_q)
        IDLE: begin
          if (take) begin
            isr_return_q <= bus.pc_next;
            active_id_q  <= sel_id;
            state_q      <= IN_ISR;
          end
        end
        IN_ISR: begin
          if (bus.boundary && bus.mret) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.interrupt  = take;
  assign bus.isr_target = (eligible != '0)
                          ? VECTOR_BASE + 16'(int'(sel_id) * VECTOR_STRIDE)
                          : 16'h0000;
  assign bus.isr_return = isr_return_q;
  assign bus.in_isr     = (state_q == IN_ISR);
  assign bus.active_id  = active_id_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
// Drives directed scenarios followed by random traffic. Each cycle the driver
// computes the expected outputs from a behavioural model and queues them; a
// monitor pops one record per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_irq_sequencer;
  localparam int NUM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_sequencer_if #(.NUM_IRQ(NUM)) bus ();

  irq_sequencer #(
    .NUM_IRQ      (NUM),
    .VECTOR_BASE  (16'h0010),
    .VECTOR_STRIDE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        intr;
    logic [15:0] tgt;
    logic        inisr;
    logic [3:0]  pend;
    logic [15:0] ret;
    logic [1:0]  id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Next-cycle stimulus
  logic        n_rst, n_bnd, n_mret, n_cwe, n_cgie, n_clr;
  logic [3:0]  n_irq, n_cmask, n_cbits;
  logic [15:0] n_pc;

  // Reference model state
  bit          m_known = 0;
  bit [3:0]    m_pend, m_mask, m_prev;
  bit          m_gie, m_inisr;
  bit [15:0]   m_ret;
  int          m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    n_rst = 1'b1; n_bnd = 1'b0; n_mret = 1'b0; n_cwe = 1'b0; n_clr = 1'b0;
    n_cbits = '0;
  endtask

  // One clock cycle: apply stimulus, queue expectation, advance the model.
  task automatic step();
    exp_t e;
    int   sel;
    bit   any, tk;
    @(posedge clk);
    #1;
    reset        = n_rst;
    bus.irq_in   = n_irq;
    bus.boundary = n_bnd;
    bus.pc_next  = n_pc;
    bus.mret     = n_mret;
    bus.cfg_we   = n_cwe;
    bus.cfg_mask = n_cmask;
    bus.cfg_gie  = n_cgie;
    bus.clr_we   = n_clr;
    bus.clr_bits = n_cbits;

    any = 0; sel = 0;
    if (m_gie) begin
      for (int i = 0; i < NUM; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          any = 1; sel = i; break;
        end
      end
    end
    tk = !m_inisr && n_bnd && !n_mret && any;

    if (m_known) begin
      e.intr  = tk;
      e.tgt   = any ? (16'h0010 + 16'(4 * sel)) : 16'h0000;
      e.inisr = m_inisr;
      e.pend  = m_pend;
      e.ret   = m_ret;
      e.id    = 2'(m_id);
      q.push_back(e);
    end

    if (!n_rst) begin
      m_known = 1; m_pend = 0; m_mask = 0; m_prev = 0; m_gie = 0;
      m_inisr = 0; m_ret = 0; m_id = 0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (n_irq[i] && !m_prev[i])      m_pend[i] = 1;
        else if (tk && sel == i)         m_pend[i] = 0;
        else if (n_clr && n_cbits[i])    m_pend[i] = 0;
      end
      m_prev = n_irq;
      if (n_cwe) begin
        m_mask = n_cmask; m_gie = n_cgie;
      end
      if (tk) begin
        m_inisr = 1; m_ret = n_pc; m_id = sel;
      end else if (m_inisr && n_bnd && n_mret) begin
        m_inisr = 0;
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_interrupt",  bus.interrupt,  e.intr);
        chk("mon_isr_target", bus.isr_target, e.tgt);
        chk("mon_in_isr",     bus.in_isr,     e.inisr);
        chk("mon_pending",    bus.pending,    e.pend);
        chk("mon_isr_return", bus.isr_return, e.ret);
        chk("mon_active_id",  bus.active_id,  e.id);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.irq_in = '0; bus.boundary = 0; bus.pc_next = '0; bus.mret = 0;
    bus.cfg_we = 0; bus.cfg_mask = '0; bus.cfg_gie = 0; bus.clr_we = 0;
    bus.clr_bits = '0;
    quiet(); n_irq = '0; n_pc = 16'h0100; n_cmask = '0; n_cgie = 0;

    // Reset
    n_rst = 0; step(); step();
    quiet(); step(); settle();
    chk("rst_in_isr", bus.in_isr, 1'b0);
    chk("rst_pending", bus.pending, 4'b0000);
    chk("rst_isr_return", bus.isr_return, 16'h0000);

    // 1. Single request
    n_cwe = 1; n_cmask = 4'b0001; n_cgie = 1; step();
    quiet(); n_irq = 4'b0001; step();
    n_irq = 4'b0000; n_bnd = 1; n_pc = 16'h0104; step(); settle();
    chk("t1_interrupt", bus.interrupt, 1'b1);
    chk("t1_target", bus.isr_target, 16'h0010);
    quiet(); step(); settle();
    chk("t1_return", bus.isr_return, 16'h0104);
    chk("t1_in_isr", bus.in_isr, 1'b1);
    chk("t1_pending", bus.pending, 4'b0000);
    n_bnd = 1; n_mret = 1; step();
    quiet();

    // 2. Priority
    n_cwe = 1; n_cmask = 4'b1111; n_cgie = 1; step();
    quiet(); n_irq = 4'b1010; step();
    n_bnd = 1; n_pc = 16'h0200; step(); settle();
    chk("t2_target1", bus.isr_target, 16'h0014);
    quiet(); step(); settle();
    chk("t2_active_id", bus.active_id, 2'd1);
    chk("t2_pending", bus.pending, 4'b1000);
    n_bnd = 1; n_mret = 1; step(); settle();
    chk("t2_mret_int", bus.interrupt, 1'b0);
    quiet(); n_bnd = 1; n_pc = 16'h0300; step(); settle();
    chk("t2_int3", bus.interrupt, 1'b1);
    chk("t2_target3", bus.isr_target, 16'h001C);
    quiet(); n_bnd = 1; n_mret = 1; step();
    quiet(); n_irq = 4'b0000; step();

    // 3. Masking
    n_cwe = 1; n_cmask = 4'b0000; n_cgie = 1; step();
    quiet(); n_irq = 4'b0100; step();
    for (int k = 0; k < 3; k++) begin
      n_bnd = 1; n_pc = 16'h0400 + 16'(k); step(); settle();
      chk("t3_masked_int", bus.interrupt, 1'b0);
    end
    chk("t3_pending", bus.pending, 4'b0100);
    quiet(); n_cwe = 1; n_cmask = 4'b0100; n_cgie = 1; step();
    quiet(); n_bnd = 1; step(); settle();
    chk("t3_int", bus.interrupt, 1'b1);
    chk("t3_target", bus.isr_target, 16'h0018);
    quiet(); n_bnd = 1; n_mret = 1; step();

    // 4. MRET/interrupt collision
    quiet(); n_cwe = 1; n_cmask = 4'b1111; n_cgie = 1; n_irq = 4'b0000; step();
    quiet(); n_irq = 4'b0010; step();
    n_bnd = 1; n_pc = 16'h0500; step();
    quiet(); n_irq = 4'b0011; step();
    n_bnd = 1; n_mret = 1; step(); settle();
    chk("t4_collide_int", bus.interrupt, 1'b0);
    quiet(); step(); settle();
    chk("t4_in_isr", bus.in_isr, 1'b0);
    chk("t4_no_bnd_int", bus.interrupt, 1'b0);
    n_bnd = 1; step(); settle();
    chk("t4_reentry", bus.interrupt, 1'b1);
    chk("t4_target", bus.isr_target, 16'h0010);
    quiet(); n_bnd = 1; n_mret = 1; step();

    // 5. Set/clear collision and level hold
    quiet(); n_irq = 4'b0000; step();
    n_irq = 4'b0001; n_clr = 1; n_cbits = 4'b0001; step();
    quiet(); step(); settle();
    chk("t5_set_wins", bus.pending[0], 1'b1);
    n_bnd = 1; step();
    quiet(); step(); settle();
    chk("t5_cleared", bus.pending[0], 1'b0);
    n_bnd = 1; n_mret = 1; step();
    for (int k = 0; k < 3; k++) begin
      quiet(); n_bnd = 1; step(); settle();
      chk("t5_level_hold", bus.interrupt, 1'b0);
    end

    // 6. Reset mid-ISR
    quiet(); n_irq = 4'b0000; step();
    n_irq = 4'b1000; step();
    n_bnd = 1; n_pc = 16'h0600; step();
    quiet(); n_irq = 4'b1110; step();
    step(); settle();
    chk("t6_pre_pending", bus.pending, 4'b0110);
    chk("t6_pre_in_isr", bus.in_isr, 1'b1);
    n_rst = 0; step();
    quiet(); n_irq = 4'b0000; step(); settle();
    chk("t6_in_isr", bus.in_isr, 1'b0);
    chk("t6_pending", bus.pending, 4'b0000);
    chk("t6_return", bus.isr_return, 16'h0000);
    n_irq = 4'b0001; step();
    for (int k = 0; k < 3; k++) begin
      n_bnd = 1; step(); settle();
      chk("t6_no_int", bus.interrupt, 1'b0);
    end

    // Random traffic
    quiet();
    for (int c = 0; c < 3000; c++) begin
      quiet();
      for (int i = 0; i < NUM; i++)
        if ($urandom_range(7) == 0) n_irq[i] = ~n_irq[i];
      n_bnd  = ($urandom_range(1) == 1);
      n_mret = n_bnd && ($urandom_range(2) == 0);
      n_pc   = 16'($urandom);
      if ($urandom_range(19) == 0) begin
        n_cwe = 1; n_cmask = 4'($urandom); n_cgie = ($urandom_range(7) != 0);
      end
      if ($urandom_range(9) == 0) begin
        n_clr = 1; n_cbits = 4'($urandom);
      end
      if ($urandom_range(299) == 0) begin
        n_rst = 0; n_bnd = 0; n_mret = 0;
      end
      step();
    end

    quiet(); step();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Single-level interrupt controller that sequences the program counter between normal flow, ISR entry and MRET return. It latches edge-triggered interrupt requests and applies a mask. It selects the highest-priority eligible request at an instruction boundary. On that boundary it drives `interrupt`, `isr_target` and `isr_return` into the PC register. It sits between the peripherals and the core control FSM. The core control FSM supplies the boundary, next-PC and MRET indications.

Parameters:
- NUM_IRQ, 4, number of request lines (1..16); ID_W = max(1, clog2(NUM_IRQ)).
- VECTOR_BASE, 16'h0010, address of the vector for IRQ 0.
- VECTOR_STRIDE, 4, byte distance between consecutive vectors.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- irq_in  in  NUM_IRQ  raw request lines, already synchronous to clk; rising edge requests
- boundary  in  1  core will assert pcflag this cycle (an instruction is completing)
- pc_next  in  16  PC value the core would load at this boundary without interrupt
- mret  in  1  completing instruction is MRET; only meaningful with boundary=1
- cfg_we  in  1  write mask/global enable
- cfg_mask  in  NUM_IRQ  new mask value (1 = enabled)
- cfg_gie  in  1  new global interrupt enable
- clr_we  in  1  clear pending bits
- clr_bits  in  NUM_IRQ  bits to clear
- interrupt  out  1  take ISR this cycle (combinational)
- isr_target  out  16  vector of the selected IRQ (combinational)
- isr_return  out  16  saved return PC (registered)
- in_isr  out  1  ISR active
- active_id  out  ID_W  ID of the IRQ being serviced
- pending  out  NUM_IRQ  pending register

Behaviour:
- **Reset** (reset==0 at a posedge):
  - pending=0, mask=0, gie=0, irq_prev=0, state=IDLE.
  - isr_return=0, active_id=0.
  - interrupt=0 follows, because state=IDLE and gie=0.
  - Reset overrides all other events in the same cycle, including an ISR in progress.
- **Edge detection:**
  - rise = irq_in & ~irq_prev; irq_prev <= irq_in every cycle.
  - A level held high produces one request only.
- **Pending update** per bit, priority highest first:
  1. rise sets the bit.
  2. Otherwise a taken interrupt for that ID clears it.
  3. Otherwise clr_we with clr_bits clears it.
  - Set wins over any same-cycle clear.
  - Masked requests still become pending.
- **Eligibility:**
  - eligible = pending & mask, qualified by gie.
  - Selection is a fixed-priority encoder; the lowest index wins.
  - Selection uses the registered pending value, so a rise is visible one cycle later.
- **Vector:**
  - isr_target = VECTOR_BASE + sel_id*VECTOR_STRIDE, truncated to 16 bits.
  - isr_target is driven whenever eligible is non-zero; it is 0 otherwise.
- **State machine:**
  - IDLE:
    - interrupt = boundary & ~mret & (eligible != 0).
    - On interrupt at the posedge: isr_return <= pc_next, active_id <= sel_id, clear pending[sel_id], state <= IN_ISR.
  - IN_ISR:
    - interrupt=0; there is no nesting, and requests accumulate in pending.
    - boundary & mret returns to IDLE at the posedge.
    - The core loads isr_return in that same cycle.
    - isr_return and active_id keep their values after the return.
  - in_isr = (state==IN_ISR).
- **MRET and interrupt in the same cycle:** MRET has precedence and interrupt stays 0. The earliest re-entry is the next boundary after the return, which guarantees at least one instruction executes at the return address.
- **MRET while IDLE:** no state change and isr_return is unchanged.
- **Configuration:** cfg_we updates mask and gie at the posedge. The new values affect eligibility from the next cycle onward; this applies in either state.
- **Latency:**
  - Request edge at cycle N gives pending at N+1.
  - With gie and mask set and boundary asserted, interrupt can assert in the same cycle as pending becomes visible (N+1).

Test Plan:
1. **Single request:**
   - Stimulus: gie=1, mask=4'b0001; pulse irq_in[0]; at a boundary with pc_next=16'h0104.
   - Required: interrupt=1, isr_target=16'h0010; after the edge isr_return=16'h0104, in_isr=1, pending=0.
2. **Priority:**
   - Stimulus: irq_in[3] and irq_in[1] rise together, all enabled, then a boundary.
   - Required: active_id=1, isr_target=16'h0014, pending=4'b1000.
   - Then: MRET boundary, then next boundary services ID 3 with isr_target=16'h001C.
3. **Masking:**
   - Stimulus: mask=0, rise on irq_in[2], several boundaries.
   - Required: interrupt stays 0 and pending=4'b0100.
   - Then: write mask=4'b0100; next boundary gives interrupt=1, isr_target=16'h0018.
4. **MRET/interrupt collision:**
   - Stimulus: in ISR with irq 0 pending, boundary with mret=1.
   - Required: interrupt=0, in_isr goes to 0; interrupt asserts at the following boundary, not earlier.
5. **Set/clear collision and level hold:**
   - Stimulus: clr_we clearing bit 0 in the same cycle as a rise on irq_in[0].
   - Required: pending[0]=1 (set wins).
   - Stimulus: hold irq_in[0] high across service.
   - Required: no second request.
6. **Reset mid-ISR:**
   - Stimulus: reset=0 for one cycle while in_isr=1 with pending=4'b0110.
   - Required: in_isr=0, pending=0, isr_return=0, mask=0, gie=0; no interrupt at subsequent boundaries until reconfigured.
